// File: rtl/FIR_pkg.sv
// Shared types and constants for the decimating FIR estimator and its
// multi-cycle add/subtract adder. This package is used by the sequencer
// and by its history sub-block.
package FIR_pkg;

    // Largest operand count the multi-cycle adder can handle.
    localparam int MAX_NUM_ADDITIONS = 16;

    // The adder walks every operand slot serially, so its result appears a
    // fixed number of cycles after it samples start.
    localparam int MCA_LATENCY = MAX_NUM_ADDITIONS;

    // States of the sequencer that drives the adder.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_START,
        SEQ_WAIT,
        SEQ_CAPTURE
    } state_seq_e;

endpackage

// File: rtl/mca_ctrl_history.sv
// Control-bit history and decimation phase for the MCA sequencer.
// Shifts the serial CBADC control bits into a history register, with the
// newest bit at index 0. Every DOWNSAMPLE accepted bits it flags a snapshot
// as due. The snapshot is the history including the bit accepted in that
// same cycle, so the next-state history is exported rather than the
// registered one.
module mca_ctrl_history
    import FIR_pkg::*;
#(
    parameter int NUM_ADDITIONS = 16,
    parameter int DOWNSAMPLE    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    input  logic                     s_bit,
    output logic [NUM_ADDITIONS-1:0] hist_next,
    output logic                     snapshot_due
);

    // A sample counter that is 8 bits wide covers every legal DOWNSAMPLE value (2..255).
    localparam logic [7:0] LAST_PHASE = 8'(DOWNSAMPLE - 1);

    logic [NUM_ADDITIONS-1:0] hist;
    logic [7:0]               sample_count;

    // The next history shifts the new bit in at index 0. The oldest bit drops out
    // through the truncating cast, which also works for a single-entry history.
    always_comb begin
        hist_next = hist;
        if (s_valid) begin
            hist_next = NUM_ADDITIONS'({hist, s_bit});
        end
    end

    assign snapshot_due = s_valid && (sample_count == LAST_PHASE);

    // The history register keeps shifting in every sequencer state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else begin
            hist <= hist_next;
        end
    end

    // The decimation counter runs on every accepted bit, even when a snapshot
    // is dropped, so that the output phase stays locked to the input stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_count <= '0;
        end else if (s_valid) begin
            if (sample_count == LAST_PHASE) begin
                sample_count <= '0;
            end else begin
                sample_count <= sample_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mca_sequencer.sv
// Initiator side of the multi-cycle add/subtract protocol.
// Each decimation period, this block freezes a snapshot of the control-bit
// history and a copy of the coefficient set, and pulses start to the adder.
// It then waits for the fixed adder latency and captures the adder result
// as one estimator output with a one-cycle valid strobe. The adder itself
// is instantiated beside this block, not inside it.
module mca_sequencer
    import FIR_pkg::*;
#(
    parameter int WIDTH_COEFFICIENT = 32,
    parameter int NUM_ADDITIONS     = 16,
    parameter int DOWNSAMPLE        = 4
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               s_valid,
    input  logic                                               s_bit,
    input  logic [NUM_ADDITIONS-1:0][WIDTH_COEFFICIENT-1:0]    coeffs,
    output logic                                               mca_start,
    output logic                                               mca_enable,
    output logic [NUM_ADDITIONS-1:0][WIDTH_COEFFICIENT-1:0]    mca_operands,
    output logic [NUM_ADDITIONS-1:0]                           mca_s_values,
    input  logic signed [WIDTH_COEFFICIENT-1:0]                mca_res,
    output logic signed [WIDTH_COEFFICIENT-1:0]                out_data,
    output logic                                               out_valid,
    output logic                                               overrun
);

    localparam int                BUSY_W    = $clog2(MCA_LATENCY + 1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MCA_LATENCY);
    localparam logic [BUSY_W-1:0] BUSY_ONE  = BUSY_W'(1);

    state_seq_e               state;
    logic [BUSY_W-1:0]        busy_count;
    logic [NUM_ADDITIONS-1:0] hist_next;
    logic                     snapshot_due;
    logic                     busy;

    mca_ctrl_history #(
        .NUM_ADDITIONS (NUM_ADDITIONS),
        .DOWNSAMPLE    (DOWNSAMPLE)
    ) u_history (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_bit        (s_bit),
        .hist_next    (hist_next),
        .snapshot_due (snapshot_due)
    );

    // While a start is pending or the adder is working, a new snapshot cannot be taken.
    assign busy = (state == SEQ_START) || (state == SEQ_WAIT);

    // Enable rises after reset and is never dropped, because the adder clears its result while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mca_enable <= 1'b0;
        end else begin
            mca_enable <= 1'b1;
        end
    end

    // The overrun flag is sticky. It records any snapshot that fell due while the adder was busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (snapshot_due && busy) begin
            overrun <= 1'b1;
        end
    end

    // The sequencer FSM registers every protocol output. The operands and
    // s_values stay frozen from the snapshot until the next accepted one,
    // because the adder indexes them serially during the wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SEQ_IDLE;
            busy_count   <= '0;
            mca_start    <= 1'b0;
            mca_s_values <= '0;
            mca_operands <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
        end else begin
            mca_start <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (snapshot_due) begin
                        mca_s_values <= hist_next;
                        mca_operands <= coeffs;
                        mca_start    <= 1'b1;
                        state        <= SEQ_START;
                    end
                end
                SEQ_START: begin
                    busy_count <= BUSY_ONE;
                    state      <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (busy_count == BUSY_LAST) begin
                        out_data  <= mca_res;
                        out_valid <= 1'b1;
                        state     <= SEQ_CAPTURE;
                    end else begin
                        busy_count <= busy_count + BUSY_ONE;
                    end
                end
                SEQ_CAPTURE: begin
                    if (snapshot_due) begin
                        mca_s_values <= hist_next;
                        mca_operands <= coeffs;
                        mca_start    <= 1'b1;
                        state        <= SEQ_START;
                    end else begin
                        state <= SEQ_IDLE;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mca_sequencer.sv
// Directed self-checking bench for mca_sequencer. A behavioural multi-cycle
// adder sits beside the DUT. It samples start together with operand 0 and
// adds one operand per cycle after that, so its result is complete
// MCA_LATENCY edges after the start-sample edge. A reference history model
// predicts the snapshot contents and the resulting sums.
module tb_mca_sequencer;
    import FIR_pkg::*;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int DS = 4;
    localparam int SNAP_TO_OUT = MCA_LATENCY + 2;

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         s_valid;
    logic                         s_bit;
    logic [N-1:0][W-1:0]          coeffs;
    logic                         mca_start;
    logic                         mca_enable;
    logic [N-1:0][W-1:0]          mca_operands;
    logic [N-1:0]                 mca_s_values;
    logic signed [W-1:0]          mca_res;
    logic signed [W-1:0]          out_data;
    logic                         out_valid;
    logic                         overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mca_sequencer #(
        .WIDTH_COEFFICIENT (W),
        .NUM_ADDITIONS     (N),
        .DOWNSAMPLE        (DS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_bit        (s_bit),
        .coeffs       (coeffs),
        .mca_start    (mca_start),
        .mca_enable   (mca_enable),
        .mca_operands (mca_operands),
        .mca_s_values (mca_s_values),
        .mca_res      (mca_res),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .overrun      (overrun)
    );

    // Free-running clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multi-cycle adder
    logic signed [W-1:0] acc;
    int                  add_idx;
    logic                add_active;
    assign mca_res = acc;

    function automatic logic signed [W-1:0] term(input logic sv, input logic [W-1:0] c);
        return sv ? $signed(c) : -$signed(c);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0; add_idx <= 0; add_active <= 1'b0;
        end else if (!mca_enable) begin
            acc <= '0; add_active <= 1'b0;
        end else if (mca_start) begin
            acc <= term(mca_s_values[0], mca_operands[0]);
            add_idx <= 1; add_active <= 1'b1;
        end else if (add_active) begin
            acc <= acc + term(mca_s_values[add_idx], mca_operands[add_idx]);
            add_idx <= add_idx + 1;
            if (add_idx == N - 1) add_active <= 1'b0;
        end
    end

    // Event logger, sampled mid-cycle
    logic signed [W-1:0] out_q[$];
    int                  out_cyc_q[$];
    int                  start_cyc_q[$];
    always @(negedge clk) begin
        if (mca_start) start_cyc_q.push_back(cyc);
        if (out_valid) begin
            out_q.push_back(out_data);
            out_cyc_q.push_back(cyc);
        end
    end

    // Reference history / decimation model
    logic [N-1:0] model_hist;
    int           model_cnt;
    logic [N-1:0] snap_q[$];
    int           snap_cyc_q[$];

    task automatic model_reset();
        model_hist = '0;
        model_cnt  = 0;
        snap_q.delete();
        snap_cyc_q.delete();
    endtask

    task automatic clear_logs();
        out_q.delete(); out_cyc_q.delete(); start_cyc_q.delete();
        snap_q.delete(); snap_cyc_q.delete();
    endtask

    function automatic logic signed [W-1:0] model_sum(input logic [N-1:0] h);
        logic signed [W-1:0] s = '0;
        for (int i = 0; i < N; i++) begin
            if (h[i]) s = s + $signed(coeffs[i]);
            else      s = s - $signed(coeffs[i]);
        end
        return s;
    endfunction

    function automatic logic signed [63:0] out_at(input int i);
        if (i < out_q.size()) return 64'(out_q[i]);
        return 'x;
    endfunction

    function automatic int out_cyc_at(input int i);
        if (i < out_cyc_q.size()) return out_cyc_q[i];
        return -100000;
    endfunction

    function automatic int start_cyc_at(input int i);
        if (i < start_cyc_q.size()) return start_cyc_q[i];
        return -100000;
    endfunction

    function automatic logic signed [63:0] exp_at(input int i);
        if (i < snap_q.size()) return 64'(model_sum(snap_q[i]));
        return 64'sd123456789;
    endfunction

    function automatic int snap_cyc_at(input int i);
        if (i < snap_cyc_q.size()) return snap_cyc_q[i];
        return 100000;
    endfunction

    // One accepted control bit, mirrored into the reference model
    task automatic apply_stimulus(input logic b);
        s_valid = 1'b1;
        s_bit   = b;
        model_hist = N'({model_hist, b});
        if (model_cnt == DS - 1) begin
            snap_q.push_back(model_hist);
            snap_cyc_q.push_back(cyc);
            model_cnt = 0;
        end else begin
            model_cnt++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_bit   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_output(input string tag, input logic signed [63:0] obs,
                                input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Directed test sequence
    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_bit   = 1'b0;
        for (int i = 0; i < N; i++) coeffs[i] = 32'd1;
        model_reset();

        // Reset state, then a long stretch with no samples
        idle(3);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_mca_start", mca_start, 0);
        check_output("rst_mca_enable", mca_enable, 0);
        check_output("rst_overrun", overrun, 0);
        check_output("rst_out_data", out_data, 0);
        check_output("rst_s_values", mca_s_values, 0);
        reset = 1'b0;
        clear_logs();
        idle(1);
        check_output("enable_after_release", mca_enable, 1);
        idle(100);
        check_output("idle_no_start", start_cyc_q.size(), 0);
        check_output("idle_no_valid", out_q.size(), 0);
        check_output("idle_enable_held", mca_enable, 1);

        // All-ones coefficients, ones fed slowly: history fills 4 bits per output
        $display("[TB] all-ones coefficients, spaced samples");
        clear_logs();
        for (int n = 0; n < 16; n++) begin
            apply_stimulus(1'b1);
            idle(4);
        end
        idle(20);
        check_output("ones_out_count", out_q.size(), 4);
        check_output("ones_out0", out_at(0), -8);
        check_output("ones_out1", out_at(1), 0);
        check_output("ones_out2", out_at(2), 8);
        check_output("ones_out3", out_at(3), 16);
        check_output("ones_start_lat", start_cyc_at(0) - snap_cyc_at(0), 1);
        for (int k = 0; k < 4; k++)
            check_output("ones_out_lat", out_cyc_at(k) - snap_cyc_at(k), SNAP_TO_OUT);
        check_output("ones_no_overrun", overrun, 0);

        // Ramp coefficients with alternating bits, newest bit last = 1
        $display("[TB] ramp coefficients, alternating bits");
        for (int i = 0; i < N; i++) coeffs[i] = 32'(i);
        clear_logs();
        for (int n = 0; n < 16; n++) begin
            apply_stimulus(1'(n % 2));
            idle(4);
        end
        idle(20);
        check_output("alt_out_count", out_q.size(), 4);
        for (int k = 0; k < 4; k++)
            check_output("alt_out_model", out_at(k), exp_at(k));
        check_output("alt_final_value", out_at(3), -8);
        check_output("alt_s_values", mca_s_values, 16'h5555);

        // Back-to-back samples: snapshots arrive faster than the adder finishes
        $display("[TB] continuous samples, overrun");
        clear_logs();
        for (int n = 0; n < 7; n++) apply_stimulus(1'b1);
        check_output("ovr_before_second", overrun, 0);
        apply_stimulus(1'b1);
        check_output("ovr_after_second", overrun, 1);
        for (int n = 0; n < 32; n++) apply_stimulus(1'b1);
        idle(25);
        check_output("ovr_out_count", out_q.size(), 2);
        check_output("ovr_start_count", start_cyc_q.size(), 2);
        check_output("ovr_out0", out_at(0), exp_at(0));
        check_output("ovr_out1", out_at(1), exp_at(5));
        check_output("ovr_out1_value", out_at(1), 120);
        check_output("ovr_out1_lat", out_cyc_at(1) - snap_cyc_at(5), SNAP_TO_OUT);
        check_output("ovr_spacing_ok", (out_cyc_at(1) - out_cyc_at(0)) >= SNAP_TO_OUT, 1);
        check_output("ovr_sticky", overrun, 1);

        // Snapshot falling due exactly in the capture cycle
        $display("[TB] snapshot due during capture");
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_reset();
        idle(1);
        check_output("cap_overrun_cleared", overrun, 0);
        clear_logs();
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        apply_stimulus(1'b0);
        apply_stimulus(1'b0);
        apply_stimulus(1'b1);
        idle(14);
        apply_stimulus(1'b1);
        idle(25);
        check_output("cap_due_cycle", snap_cyc_at(1) - snap_cyc_at(0), SNAP_TO_OUT);
        check_output("cap_out_count", out_q.size(), 2);
        check_output("cap_back_to_back", start_cyc_at(1) - out_cyc_at(0), 1);
        check_output("cap_out0", out_at(0), exp_at(0));
        check_output("cap_out1", out_at(1), exp_at(1));
        check_output("cap_no_overrun", overrun, 0);

        // Reset while the adder is busy, then restart from clean history
        $display("[TB] reset during wait");
        clear_logs();
        for (int n = 0; n < 4; n++) apply_stimulus(1'b1);
        idle(6);
        check_output("abort_started", start_cyc_q.size(), 1);
        reset = 1'b1;
        #1;
        check_output("abort_out_valid", out_valid, 0);
        check_output("abort_s_values", mca_s_values, 0);
        check_output("abort_enable", mca_enable, 0);
        idle(2);
        reset = 1'b0;
        model_reset();
        clear_logs();
        idle(30);
        check_output("abort_no_stale", out_q.size(), 0);
        for (int n = 0; n < 4; n++) apply_stimulus(1'b1);
        idle(25);
        check_output("post_rst_out_count", out_q.size(), 1);
        check_output("post_rst_value", out_at(0), -108);
        check_output("post_rst_model", out_at(0), exp_at(0));
        check_output("post_rst_s_values", mca_s_values, 16'h000F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
